// File: rtl/pwm_duty_ramp.sv
// pwm_duty_ramp
//
// Brightness ramp controller sitting in front of the backlight PWM generator.
// A new target duty is accepted over a valid/ready handshake. The duty output
// then walks toward that target by step_in once every TICK_DIV clocks. It never
// overshoots the target and never wraps around the DUTY_W range.
//
// Optional feature macro: SYNC_PERIOD_EN
//   defined   : each ramp step is parked in a pending register and only applied
//               on period_end_in, so the PWM never sees a mid-period change.
//   undefined : ramp steps write duty_out directly, period_end_in is unused and
//               target_ready_out is always 1.
//
// Ports
//   clk_in            system clock, rising edge
//   rst_n_in          asynchronous active-low reset
//   target_in         requested final duty
//   target_valid_in   target_in is valid
//   target_ready_out  block can accept a target
//   step_in           step magnitude, sampled at each tick (0 acts as 1)
//   period_end_in     one-cycle strobe at the end of a PWM period
//   duty_out          registered duty value to the PWM generator
//   busy_out          high while a ramp or period wait is in progress
//   done_out          one-cycle pulse when duty_out reaches the target
module pwm_duty_ramp #(
    parameter int          DUTY_W     = 8,
    parameter int          TICK_DIV   = 50000,
    parameter int unsigned RESET_DUTY = 0
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic [DUTY_W-1:0] target_in,
    input  logic              target_valid_in,
    output logic              target_ready_out,
    input  logic [DUTY_W-1:0] step_in,
    input  logic              period_end_in,
    output logic [DUTY_W-1:0] duty_out,
    output logic              busy_out,
    output logic              done_out
);

    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TICK_DIV - 1);
    localparam logic [DUTY_W-1:0] RESET_VAL = DUTY_W'(RESET_DUTY);

`ifdef SYNC_PERIOD_EN
    typedef enum logic [1:0] {IDLE = 2'd0, RAMP = 2'd1, WAIT_PERIOD = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, RAMP = 2'd1} state_t;
`endif

    state_t            state, state_next;
    logic [DUTY_W-1:0] duty, duty_next;
    logic [DUTY_W-1:0] target, target_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic              done, done_next;
    logic              ready;
    logic              accept;
    logic              tick;
    logic [DUTY_W-1:0] goal;
    logic [DUTY_W-1:0] step_eff;
    logic [DUTY_W:0]   sum;
    logic [DUTY_W-1:0] diff;
    logic [DUTY_W-1:0] ramp_val;

`ifdef SYNC_PERIOD_EN
    logic [DUTY_W-1:0] pending, pending_next;
    assign ready = (state != WAIT_PERIOD);
`else
    logic unused_period_end;
    assign unused_period_end = period_end_in;
    assign ready = 1'b1;
`endif

    assign accept   = target_valid_in & ready;
    assign tick     = (state == RAMP) && (cnt == CNT_LAST);
    // A retarget that lands on a tick edge steps toward the new target.
    assign goal     = accept ? target_in : target;
    assign step_eff = (step_in == '0) ? DUTY_W'(1) : step_in;
    // One extra bit on the upward sum so large steps cannot wrap past the top.
    assign sum      = {1'b0, duty} + {1'b0, step_eff};
    assign diff     = duty - goal;

    // Clamped next ramp value; whenever the remaining distance is within one
    // step the output lands exactly on the goal.
    always_comb begin
        ramp_val = goal;
        if (duty < goal) begin
            ramp_val = (sum >= {1'b0, goal}) ? goal : sum[DUTY_W-1:0];
        end else if (diff > step_eff) begin
            ramp_val = duty - step_eff;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state  <= IDLE;
            duty   <= RESET_VAL;
            target <= RESET_VAL;
            cnt    <= '0;
            done   <= 1'b0;
`ifdef SYNC_PERIOD_EN
            pending <= '0;
`endif
        end else begin
            state  <= state_next;
            duty   <= duty_next;
            target <= target_next;
            cnt    <= cnt_next;
            done   <= done_next;
`ifdef SYNC_PERIOD_EN
            pending <= pending_next;
`endif
        end
    end

    // Next-state logic: handshake, tick counting, ramp steps and arrival.
    always_comb begin
        state_next  = state;
        duty_next   = duty;
        target_next = target;
        cnt_next    = cnt;
        done_next   = 1'b0;
`ifdef SYNC_PERIOD_EN
        pending_next = pending;
`endif
        case (state)
            IDLE: begin
                if (accept) begin
                    target_next = target_in;
                    if (target_in == duty) begin
                        done_next = 1'b1;
                    end else begin
                        state_next = RAMP;
                        cnt_next   = '0;
                    end
                end
            end
            RAMP: begin
                cnt_next = tick ? '0 : cnt + CNT_W'(1);
                if (accept) begin
                    target_next = target_in;
                end
                if (accept && (target_in == duty)) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end else if (tick) begin
`ifdef SYNC_PERIOD_EN
                    pending_next = ramp_val;
                    state_next   = WAIT_PERIOD;
                    cnt_next     = '0;
`else
                    duty_next = ramp_val;
                    if (ramp_val == goal) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end
`endif
                end
            end
`ifdef SYNC_PERIOD_EN
            WAIT_PERIOD: begin
                cnt_next = '0;
                if (period_end_in) begin
                    duty_next = pending;
                    if (pending == target) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else begin
                        state_next = RAMP;
                    end
                end
            end
`endif
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign duty_out         = duty;
    assign done_out         = done;
    assign busy_out         = (state != IDLE);
    assign target_ready_out = ready;

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Testbench for pwm_duty_ramp with DUTY_W=8, TICK_DIV=4, RESET_DUTY=0.
// The reference model predicts each ramp as a list of clamped arithmetic steps
// landing every TICK_DIV cycles after the accepting edge.
module tb_pwm_duty_ramp;

    localparam int DUTY_W   = 8;
    localparam int TICK_DIV = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DUTY_W-1:0] target = '0;
    logic              target_valid = 1'b0;
    logic              target_ready;
    logic [DUTY_W-1:0] step = '0;
    logic              period_end = 1'b0;
    logic [DUTY_W-1:0] duty;
    logic              busy;
    logic              done;

    int compared   = 0;
    int mismatched = 0;
    int model_duty = 0;

    pwm_duty_ramp #(
        .DUTY_W(DUTY_W),
        .TICK_DIV(TICK_DIV),
        .RESET_DUTY(0)
    ) dut (
        .clk_in(clk),
        .rst_n_in(rst_n),
        .target_in(target),
        .target_valid_in(target_valid),
        .target_ready_out(target_ready),
        .step_in(step),
        .period_end_in(period_end),
        .duty_out(duty),
        .busy_out(busy),
        .done_out(done)
    );

    always #5 clk = ~clk;

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        compared++;
        if (observed != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    // Present one target for exactly one accepting edge.
    task automatic applyStimulus(input int t, input int s);
        target       = DUTY_W'(t);
        step         = DUTY_W'(s);
        target_valid = 1'b1;
        next_edge();
        target_valid = 1'b0;
    endtask

    // Reference step: move toward t by s (0 acts as 1), clamping at t.
    function automatic int ramp_next(input int d, input int t, input int s);
        int se;
        se = (s == 0) ? 1 : s;
        if (d < t) return (d + se >= t) ? t : d + se;
        return (d - t <= se) ? t : d - se;
    endfunction

    // Accept a target from IDLE and follow the whole ramp cycle by cycle.
    task automatic ramp_check(input int t, input int s);
        applyStimulus(t, s);
        if (t == model_duty) begin
            checkOutput("idle_eq_done", done, 1);
            checkOutput("idle_eq_duty", duty, model_duty);
            checkOutput("idle_eq_busy", busy, 0);
            next_edge();
            checkOutput("idle_eq_done_clear", done, 0);
            return;
        end
        checkOutput("accept_busy", busy, 1);
        checkOutput("accept_done", done, 0);
        while (model_duty != t) begin
            for (int c = 1; c < TICK_DIV; c++) begin
                next_edge();
                checkOutput("hold_duty", duty, model_duty);
                checkOutput("hold_done", done, 0);
            end
            next_edge();
            model_duty = ramp_next(model_duty, t, s);
            checkOutput("tick_duty", duty, model_duty);
            checkOutput("tick_done", done, (model_duty == t) ? 1 : 0);
            checkOutput("tick_busy", busy, (model_duty != t) ? 1 : 0);
        end
        next_edge();
        checkOutput("done_one_cycle", done, 0);
        checkOutput("final_duty", duty, t);
    endtask

    initial begin
        // Power-on reset.
        repeat (3) next_edge();
        checkOutput("rst_duty", duty, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_ready", target_ready, 1);
        rst_n = 1'b1;
        next_edge();

        // Reset asserted in the middle of a ramp takes effect immediately.
        applyStimulus(10, 3);
        repeat (8) next_edge();
`ifndef SYNC_PERIOD_EN
        checkOutput("pre_reset_duty", duty, 6);
`endif
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrst_duty", duty, 0);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_done", done, 0);
        checkOutput("midrst_ready", target_ready, 1);
        #2 rst_n = 1'b1;
        next_edge();
        model_duty = 0;

`ifndef SYNC_PERIOD_EN
        // Directed ramps: basic, saturating up, stepping down, zero step.
        ramp_check(10, 3);
        ramp_check(250, 255);
        ramp_check(0, 100);
        ramp_check(2, 0);
        ramp_check(0, 255);

        // Retarget to the current duty mid-ramp ends the ramp at once.
        applyStimulus(10, 3);
        repeat (8) next_edge();
        checkOutput("retgt_pre_duty", duty, 6);
        applyStimulus(6, 3);
        checkOutput("retgt_done", done, 1);
        checkOutput("retgt_busy", busy, 0);
        checkOutput("retgt_duty", duty, 6);
        next_edge();
        checkOutput("retgt_done_clear", done, 0);
        model_duty = 6;

        // Same target while idle just pulses done.
        ramp_check(6, 3);

        // Randomized ramps.
        repeat (12) begin
            int t;
            int s;
            t = int'($urandom_range(0, 255));
            s = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 80));
            ramp_check(t, s);
        end
`else
        // Period-synchronised update.
        applyStimulus(8, 8);
        repeat (4) next_edge();
        checkOutput("sync_wait_ready", target_ready, 0);
        checkOutput("sync_wait_duty", duty, 0);
        checkOutput("sync_wait_busy", busy, 1);
        repeat (6) next_edge();
        checkOutput("sync_hold_duty", duty, 0);
        period_end = 1'b1;
        next_edge();
        period_end = 1'b0;
        checkOutput("sync_duty", duty, 8);
        checkOutput("sync_done", done, 1);
        checkOutput("sync_busy", busy, 0);
        checkOutput("sync_ready", target_ready, 1);
        next_edge();
        checkOutput("sync_done_clear", done, 0);
        period_end = 1'b1;
        next_edge();
        period_end = 1'b0;
        checkOutput("sync_idle_pe_duty", duty, 8);
        checkOutput("sync_idle_pe_done", done, 0);
        checkOutput("sync_idle_pe_busy", busy, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
